// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte-addressed load/store request into one or two
// word-addressed memory accesses with little-endian byte lanes, then merges
// and extends load data and reports completion on a one-cycle strobe.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam int WA = ADDR_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t                r_state;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_lo;
    logic                  r_reqReady;
    logic [WA-1:0]         r_memAddr;
    logic                  r_memWe;
    logic [3:0]            r_memBe;
    logic [DATA_WIDTH-1:0] r_memWdata;
    logic                  r_rspValid;
    logic [DATA_WIDTH-1:0] r_rspData;
    logic                  r_rspErr;

    logic [3:0]            w_reqBe;
    logic [7:0]            w_curMask;
    logic                  w_split;
    logic                  w_reqIllegal;
    logic [WA-1:0]         w_word2;
    logic [5:0]            w_hiShift;
    logic [DATA_WIDTH-1:0] w_lo;
    logic [DATA_WIDTH-1:0] w_hi;
    logic [DATA_WIDTH-1:0] w_aligned;
    logic [DATA_WIDTH-1:0] w_loadData;

    // Byte-lane mask of an access spanning two words: low nibble is the first
    // word, high nibble the second word.
    function automatic logic [7:0] laneMask(input logic [1:0] sz, input logic [1:0] o);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << o;
    endfunction

    function automatic logic isIllegal(input logic we, input logic [2:0] f3);
        if (we) return f3 > 3'b010;
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    assign w_reqBe      = 4'(laneMask(req_funct3[1:0], req_addr[1:0]));
    assign w_curMask    = laneMask(r_funct3[1:0], r_addr[1:0]);
    assign w_split      = |w_curMask[7:4];
    assign w_reqIllegal = isIllegal(req_we, req_funct3);
    assign w_word2      = (r_addr[ADDR_WIDTH-1:2] + WA'(1)) % WA'(MEM_WORDS);
    assign w_hiShift    = 6'd32 - {1'b0, r_addr[1:0], 3'b000};

    // The last access of a load is merged straight from mem_rdata, so the
    // high word never needs its own buffer.
    assign w_lo      = (r_state == ACC1) ? mem_rdata : r_lo;
    assign w_hi      = (r_state == ACC2) ? mem_rdata : '0;
    assign w_aligned = DATA_WIDTH'({w_hi, w_lo} >> {r_addr[1:0], 3'b000});

    // Sign- or zero-extend the aligned load data according to funct3.
    always_comb begin
        w_loadData = '0;
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_aligned[7]}}, w_aligned[7:0]};
            3'b001:  w_loadData = {{16{w_aligned[15]}}, w_aligned[15:0]};
            3'b010:  w_loadData = w_aligned;
            3'b100:  w_loadData = {24'h0, w_aligned[7:0]};
            3'b101:  w_loadData = {16'h0, w_aligned[15:0]};
            default: w_loadData = '0;
        endcase
    end

    // Control FSM; every output is registered and set up on the edge that
    // enters the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lo       <= '0;
            r_reqReady <= 1'b1;
            r_memAddr  <= '0;
            r_memWe    <= 1'b0;
            r_memBe    <= '0;
            r_memWdata <= '0;
            r_rspValid <= 1'b0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_funct3   <= req_funct3;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_reqReady <= 1'b0;
                        if (w_reqIllegal) begin
                            r_state    <= RESP;
                            r_rspValid <= 1'b1;
                            r_rspErr   <= 1'b1;
                            r_rspData  <= '0;
                        end else begin
                            r_state    <= ACC1;
                            r_memAddr  <= req_addr[ADDR_WIDTH-1:2];
                            r_memWe    <= req_we;
                            r_memBe    <= w_reqBe;
                            r_memWdata <= req_wdata << {req_addr[1:0], 3'b000};
                        end
                    end
                end
                ACC1: begin
                    if (!r_we) r_lo <= mem_rdata;
                    if (w_split) begin
                        r_state    <= ACC2;
                        r_memAddr  <= w_word2;
                        r_memBe    <= w_curMask[7:4];
                        r_memWdata <= r_wdata >> w_hiShift;
                    end else begin
                        r_state    <= RESP;
                        r_memAddr  <= '0;
                        r_memWe    <= 1'b0;
                        r_memBe    <= '0;
                        r_memWdata <= '0;
                        r_rspValid <= 1'b1;
                        r_rspErr   <= 1'b0;
                        r_rspData  <= r_we ? '0 : w_loadData;
                    end
                end
                ACC2: begin
                    r_state    <= RESP;
                    r_memAddr  <= '0;
                    r_memWe    <= 1'b0;
                    r_memBe    <= '0;
                    r_memWdata <= '0;
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b0;
                    r_rspData  <= r_we ? '0 : w_loadData;
                end
                default: begin
                    r_state    <= IDLE;
                    r_reqReady <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = r_reqReady;
    assign mem_addr  = r_memAddr;
    assign mem_we    = r_memWe;
    assign mem_be    = r_memBe;
    assign mem_wdata = r_memWdata;
    assign rsp_valid = r_rspValid;
    assign rsp_data  = r_rspData;
    assign rsp_err   = r_rspErr;

endmodule
